// File: rtl/fp_divsqrt_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_wire (package)
// Purpose  : Shared FSM state encoding and operation-select constants for the
//            iterative mantissa divide / square-root unit.
// Revision : 1.0 - initial release
// ============================================================================
package fp_wire;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_DIV  = 1'b0;
    localparam logic OP_SQRT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fp_divsqrt_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_divsqrt_iter_if
// Purpose  : Operand / result handshake bundle for fp_divsqrt_iter.
//            master = producer/consumer side, slave = the divsqrt unit.
// Revision : 1.0 - initial release
// ============================================================================
interface fp_divsqrt_iter_if #(
    parameter int MW = 24,
    parameter int QW = MW + 2
) ();

    logic          in_valid;
    logic          in_ready;
    logic          op;
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic          odd;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] q;
    logic          sticky;

    modport master (
        output in_valid, op, a, b, odd, out_ready,
        input  in_ready, out_valid, q, sticky
    );

    modport slave (
        input  in_valid, op, a, b, odd, out_ready,
        output in_ready, out_valid, q, sticky
    );

endinterface
`default_nettype wire

// File: rtl/fp_divsqrt_step.sv
`default_nettype none
// ============================================================================
// Module   : fp_divsqrt_step
// Purpose  : One radix-2 restoring iteration, shared by divide and sqrt.
//            Divide: compare remainder with divisor, subtract, shift left.
//            Sqrt  : bring in the next radicand bit pair, compare with the
//                    trial value 4*root+1, subtract on success.
// Revision : 1.0 - initial release
// ============================================================================
module fp_divsqrt_step
    import fp_wire::*;
#(
    parameter  int MW = 24,
    localparam int QW = MW + 2,
    localparam int RW = QW + 2
) (
    input  logic [RW-1:0] rem,
    input  logic [QW-1:0] opnd,      // partial root (sqrt) or zero-extended divisor
    input  logic [1:0]    pair,      // next radicand bit pair, sqrt only
    input  logic          op,
    output logic [RW-1:0] rem_next,
    output logic          q_bit
);

    logic [RW-1:0] shifted;
    logic [RW-1:0] trial;
    logic [RW-1:0] diff;

    // Single recurrence step; the divide remainder is stored pre-shifted so the
    // next compare is directly against the divisor.
    always_comb begin
        shifted  = rem;
        trial    = RW'(opnd);
        if (op == OP_SQRT) begin
            shifted = (rem << 2) | RW'(pair);
            trial   = {opnd, 2'b01};
        end
        q_bit    = (shifted >= trial);
        diff     = shifted - trial;
        rem_next = q_bit ? diff : shifted;
        if (op == OP_DIV) begin
            rem_next = rem_next << 1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_divsqrt_iter.sv
`default_nettype none
// ============================================================================
// Module   : fp_divsqrt_iter
// Purpose  : Iterative mantissa divider / square root, one result bit per
//            cycle, MSB first. Result q has 1 integer bit and MW+1 fraction
//            bits; sticky flags a nonzero final remainder.
// Revision : 1.0 - initial release
// ============================================================================
module fp_divsqrt_iter
    import fp_wire::*;
#(
    parameter int MW = 24,
    parameter int QW = MW + 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             kill,
    fp_divsqrt_iter_if.slave bus
);

    localparam int CW = $clog2(QW);
    localparam int RW = QW + 2;

    // Working registers for one operation; widths follow MW.
    typedef struct packed {
        logic          op;
        logic [CW-1:0] cnt;
        logic [RW-1:0] rem;      // divide uses the low MW+1 bits
        logic [QW-1:0] q;        // quotient / partial root
        logic [MW-1:0] divisor;
        logic [MW:0]   rad;      // radicand bits still to be consumed, MSB first
    } work_t;

    state_t        state;
    state_t        state_next;
    work_t         r;
    logic          accept;
    logic          last_iter;
    logic [QW-1:0] step_opnd;
    logic [RW-1:0] step_rem;
    logic          step_bit;

    assign bus.in_ready  = (state == ST_IDLE) && !kill && !reset;
    assign accept        = bus.in_valid && bus.in_ready;
    assign last_iter     = (r.cnt == CW'(QW - 1));
    assign bus.out_valid = (state == ST_DONE);
    assign bus.q         = r.q;
    assign bus.sticky    = |r.rem;

    assign step_opnd = (r.op == OP_SQRT) ? r.q : QW'(r.divisor);

    fp_divsqrt_step #(.MW(MW)) u_step (
        .rem      (r.rem),
        .opnd     (step_opnd),
        .pair     (r.rad[MW -: 2]),
        .op       (r.op),
        .rem_next (step_rem),
        .q_bit    (step_bit)
    );

    // State register; reset outranks everything else.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; kill returns to IDLE from any state.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)        state_next = ST_BUSY;
            ST_BUSY: if (last_iter)     state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
        if (kill) begin
            state_next = ST_IDLE;
        end
    end

    // Operand capture on accept, then one recurrence step per BUSY cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r <= '0;
        end else if (accept) begin
            r.op      <= bus.op;
            r.cnt     <= '0;
            r.rem     <= (bus.op == OP_DIV) ? RW'(bus.a) : '0;
            r.q       <= '0;
            r.divisor <= bus.b;
            r.rad     <= bus.odd ? {bus.a, 1'b0} : {1'b0, bus.a};
        end else if (state == ST_BUSY && !kill) begin
            r.cnt <= r.cnt + CW'(1);
            r.rem <= step_rem;
            r.q   <= {r.q[QW-2:0], step_bit};
            r.rad <= r.rad << 2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_divsqrt_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_divsqrt_iter
// Purpose  : Self-checking bench for fp_divsqrt_iter (MW=24 and MW=53).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_divsqrt_iter;
    import fp_wire::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic kill  = 1'b0;
    int   cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    fp_divsqrt_iter_if #(.MW(24)) bus ();
    fp_divsqrt_iter_if #(.MW(53)) bus53 ();

    fp_divsqrt_iter #(.MW(24)) dut (
        .clock (clock),
        .reset (reset),
        .kill  (kill),
        .bus   (bus)
    );

    fp_divsqrt_iter #(.MW(53)) dut53 (
        .clock (clock),
        .reset (reset),
        .kill  (kill),
        .bus   (bus53)
    );

    typedef struct packed {
        logic [25:0] q;
        logic        sticky;
    } exp_t;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   accept_cyc = 0;

    // Reference: exact integer arithmetic on the scaled operands.
    function automatic exp_t model(input logic op_i, input logic [23:0] a_i,
                                   input logic [23:0] b_i, input logic odd_i);
        exp_t e;
        longint unsigned n, y, t;
        if (op_i == OP_DIV) begin
            n = longint'(a_i) << 25;
            e.q      = 26'(n / longint'(b_i));
            e.sticky = (n % longint'(b_i)) != 0;
        end else begin
            n = longint'(a_i) << (odd_i ? 28 : 27);
            y = 0;
            for (int k = 26; k >= 0; k--) begin
                t = y | (64'd1 << k);
                if (t * t <= n) y = t;
            end
            e.q      = 26'(y);
            e.sticky = (y * y) != n;
        end
        return e;
    endfunction

    task automatic send(input logic op_i, input logic [23:0] a_i,
                        input logic [23:0] b_i, input logic odd_i);
        int guard = 0;
        bus.op = op_i; bus.a = a_i; bus.b = b_i; bus.odd = odd_i;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clock); #1; guard++;
        end
        n_checks++;
        if (!bus.in_ready) begin
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, guard);
        end else begin
            n_pass++;
            sb.push_back(model(op_i, a_i, b_i, odd_i));
            @(posedge clock); #1;
            accept_cyc = cyc;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input logic hold_ready, output int lat);
        int   guard = 0;
        exp_t e;
        lat = -1;
        while (!bus.out_valid && guard < 200) begin
            @(posedge clock); #1; guard++;
        end
        n_checks++;
        if (!bus.out_valid || sb.size() == 0) begin
            $display("FAIL result_timeout: out_valid=%0b pending=%0d, required out_valid=1", bus.out_valid, sb.size());
        end else begin
            n_pass++;
            lat = cyc - accept_cyc;
            e = sb.pop_front();
            n_checks++;
            if (bus.q !== e.q || bus.sticky !== e.sticky)
                $display("FAIL result: q=%h sticky=%b, required q=%h sticky=%b", bus.q, bus.sticky, e.q, e.sticky);
            else
                n_pass++;
            bus.out_ready = 1'b1;
            @(posedge clock); #1;
            bus.out_ready = hold_ready;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.q !== 26'd0 || bus.sticky !== 1'b0)
            $display("FAIL reset_state: out_valid=%b in_ready=%b q=%h sticky=%b, required all 0",
                     bus.out_valid, bus.in_ready, bus.q, bus.sticky);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_release: in_ready=%b, required 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_divide();
        int lat;
        logic [23:0] ra, rb;
        send(OP_DIV, 24'h800000, 24'h800000, 1'b0);
        collect(1'b0, lat);
        n_checks++;
        if (lat !== 26) $display("FAIL div_latency: %0d cycles, required 26", lat);
        else n_pass++;
        send(OP_DIV, 24'h800000, 24'hC00000, 1'b0);
        collect(1'b0, lat);
        send(OP_DIV, 24'hFFFFFF, 24'h800000, 1'b0);
        collect(1'b0, lat);
        send(OP_DIV, 24'h800000, 24'hFFFFFF, 1'b0);
        collect(1'b0, lat);
        for (int i = 0; i < 4; i++) begin
            ra = 24'($urandom()) | 24'h800000;
            rb = 24'($urandom()) | 24'h800000;
            send(OP_DIV, ra, rb, 1'b0);
            collect(1'b0, lat);
        end
    endtask

    task automatic test_sqrt();
        int lat;
        logic [23:0] ra;
        logic        ro;
        send(OP_SQRT, 24'h800000, 24'h000000, 1'b0);
        collect(1'b0, lat);
        n_checks++;
        if (lat !== 26) $display("FAIL sqrt_latency: %0d cycles, required 26", lat);
        else n_pass++;
        send(OP_SQRT, 24'h800000, 24'h123456, 1'b1);
        collect(1'b0, lat);
        send(OP_SQRT, 24'h900000, 24'h000000, 1'b1);
        collect(1'b0, lat);
        send(OP_SQRT, 24'hFFFFFF, 24'h000000, 1'b1);
        collect(1'b0, lat);
        for (int i = 0; i < 4; i++) begin
            ra = 24'($urandom()) | 24'h800000;
            ro = 1'($urandom());
            send(OP_SQRT, ra, 24'($urandom()), ro);
            collect(1'b0, lat);
        end
    endtask

    task automatic test_backpressure();
        int          guard = 0;
        int          lat;
        logic [25:0] q0;
        logic        s0;
        int          bad = 0;
        send(OP_DIV, 24'hA00000, 24'hE00000, 1'b0);
        while (!bus.out_valid && guard < 200) begin
            @(posedge clock); #1; guard++;
        end
        q0 = bus.q; s0 = bus.sticky;
        // Offer a new operation while the result is held: it must be ignored.
        bus.op = OP_SQRT; bus.a = 24'hC00000; bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (bus.out_valid !== 1'b1 || bus.q !== q0 || bus.sticky !== s0 || bus.in_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0 || guard >= 200)
            $display("FAIL hold_in_done: %0d unstable cycles (wait %0d), required 0", bad, guard);
        else n_pass++;
        bus.in_valid = 1'b0;
        collect(1'b0, lat);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL release: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        int t0;
        bus.out_ready = 1'b1;
        send(OP_DIV, 24'hB00000, 24'h900000, 1'b0);
        t0 = accept_cyc;
        bus.op = OP_SQRT; bus.a = 24'hD00000; bus.odd = 1'b0; bus.in_valid = 1'b1;
        collect(1'b1, lat);
        send(OP_SQRT, 24'hD00000, 24'h000000, 1'b0);
        n_checks++;
        if (accept_cyc - t0 !== 28) $display("FAIL issue_period_1: %0d cycles, required 28", accept_cyc - t0);
        else n_pass++;
        t0 = accept_cyc;
        bus.op = OP_DIV; bus.a = 24'hF00000; bus.b = 24'h880000; bus.in_valid = 1'b1;
        collect(1'b1, lat);
        send(OP_DIV, 24'hF00000, 24'h880000, 1'b0);
        n_checks++;
        if (accept_cyc - t0 !== 28) $display("FAIL issue_period_2: %0d cycles, required 28", accept_cyc - t0);
        else n_pass++;
        collect(1'b0, lat);
    endtask

    task automatic test_kill();
        int   lat;
        int   saw = 0;
        exp_t dropped;
        send(OP_DIV, 24'h800000, 24'hC00000, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        kill = 1'b1;
        @(posedge clock); #1;
        kill = 1'b0;
        #1;
        dropped = sb.pop_back();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL kill_busy: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (bus.out_valid === 1'b1) saw++;
        end
        n_checks++;
        if (saw != 0) $display("FAIL kill_no_result: out_valid seen %0d cycles, required 0 (dropped q=%h)", saw, dropped.q);
        else n_pass++;
        send(OP_SQRT, 24'h800000, 24'h000000, 1'b1);
        collect(1'b0, lat);
        // kill alongside in_valid in IDLE must block the accept
        bus.op = OP_DIV; bus.a = 24'h900000; bus.b = 24'h800000; bus.in_valid = 1'b1;
        kill = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL kill_in_ready: in_ready=%b, required 0", bus.in_ready);
        else n_pass++;
        @(posedge clock); #1;
        kill = 1'b0; bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL kill_no_accept: in_ready=%b, required 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int   lat;
        int   guard = 0;
        exp_t dropped;
        send(OP_DIV, 24'hC00000, 24'hA00000, 1'b0);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.q !== 26'd0 || bus.sticky !== 1'b0)
            $display("FAIL reset_busy: out_valid=%b in_ready=%b q=%h sticky=%b, required all 0",
                     bus.out_valid, bus.in_ready, bus.q, bus.sticky);
        else n_pass++;
        reset = 1'b0;
        dropped = sb.pop_back();
        #1;
        send(OP_SQRT, 24'hE00000, 24'h000000, 1'b1);
        while (!bus.out_valid && guard < 200) begin
            @(posedge clock); #1; guard++;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.q !== 26'd0 || bus.sticky !== 1'b0 || guard >= 200)
            $display("FAIL reset_done: out_valid=%b in_ready=%b q=%h sticky=%b wait=%0d, required all 0",
                     bus.out_valid, bus.in_ready, bus.q, bus.sticky, guard);
        else n_pass++;
        reset = 1'b0;
        dropped = sb.pop_back();
        #1;
        send(OP_DIV, 24'h800000, 24'h800000, 1'b0);
        collect(1'b0, lat);
        n_checks++;
        if (lat !== 26 || dropped.q === 26'hx) $display("FAIL after_reset_latency: %0d cycles, required 26", lat);
        else n_pass++;
    endtask

    task automatic test_double();
        logic [55:0] sb53[$];
        logic [55:0] e;
        int          t0;
        int          guard = 0;
        bus53.op = OP_DIV; bus53.a = 53'd1 << 52; bus53.b = 53'd1 << 52; bus53.odd = 1'b0;
        bus53.in_valid = 1'b1;
        #1;
        n_checks++;
        if (bus53.in_ready !== 1'b1) $display("FAIL dbl_ready: in_ready=%b, required 1", bus53.in_ready);
        else n_pass++;
        sb53.push_back({55'd1 << 54, 1'b0});
        @(posedge clock); #1;
        t0 = cyc;
        bus53.in_valid = 1'b0;
        while (!bus53.out_valid && guard < 200) begin
            @(posedge clock); #1; guard++;
        end
        e = sb53.pop_front();
        n_checks++;
        if (cyc - t0 !== 55 || !bus53.out_valid)
            $display("FAIL dbl_latency: %0d cycles (out_valid=%b), required 55", cyc - t0, bus53.out_valid);
        else n_pass++;
        n_checks++;
        if (bus53.q !== e[55:1] || bus53.sticky !== e[0])
            $display("FAIL dbl_result: q=%h sticky=%b, required q=%h sticky=%b", bus53.q, bus53.sticky, e[55:1], e[0]);
        else n_pass++;
        bus53.out_ready = 1'b1;
        @(posedge clock); #1;
        bus53.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.odd = 1'b0; bus.out_ready = 1'b0;
        bus53.in_valid = 1'b0; bus53.op = 1'b0; bus53.a = '0; bus53.b = '0; bus53.odd = 1'b0; bus53.out_ready = 1'b0;
        test_reset();
        test_divide();
        test_sqrt();
        test_backpressure();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        test_double();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_divsqrt_iter.md
FP_DIVSQRT_ITER -- requirements
Module: fp_divsqrt_iter

Interface
REQ-001 SHALL have parameter MW, default 24, meaning mantissa width including the hidden bit (24 single, 53 double).
REQ-002 SHALL have parameter QW, default MW+2, fixed as MW+2, meaning result width: 1 integer bit and MW+1 fraction bits.
REQ-003 SHALL have port clock, in, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, in, 1, synchronous active-high reset.
REQ-005 SHALL have port kill, in, 1, synchronous flush of any operation in flight.
REQ-006 SHALL have port in_valid, in, 1, operands present.
REQ-007 SHALL have port in_ready, out, 1, block accepts operands this cycle.
REQ-008 SHALL have port op, in, 1, operation select: 0 = divide, 1 = square root.
REQ-009 SHALL have port a, in, MW, dividend or radicand; normalised, MSB=1.
REQ-010 SHALL have port b, in, MW, divisor; normalised, MSB=1; ignored for sqrt.
REQ-011 SHALL have port odd, in, 1, sqrt only: radicand is 2·a instead of a.
REQ-012 SHALL have port out_valid, out, 1, result present.
REQ-013 SHALL have port out_ready, in, 1, consumer takes the result.
REQ-014 SHALL have port q, out, QW, result mantissa.
REQ-015 SHALL have port sticky, out, 1, set when the result is inexact (nonzero remainder).

Function
REQ-016 SHALL treat a and b as fixed-point values in [1,2), with the MSB weighted 2^0.
REQ-017 Divide SHALL produce q = floor(a/b·2^(MW+1)) and sticky = (a·2^(MW+1) mod b != 0).
REQ-018 Sqrt SHALL set x = odd ? 2a : a, then produce q = floor(sqrt(x)·2^(MW+1)) and sticky = (q² != x·2^(2MW+2)).
REQ-019 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-020 in_ready SHALL equal (state==IDLE) && !kill && !reset.
REQ-021 On an accept edge (in_valid && in_ready), the block SHALL latch op, operands and odd, clear the iteration counter and enter BUSY.
REQ-022 BUSY SHALL resolve exactly one quotient/root bit per cycle, MSB first, for QW cycles, then enter DONE.
REQ-023 Latency SHALL be exactly QW cycles from the accept edge to out_valid being visible (26 cycles for MW=24).
REQ-024 out_valid SHALL be high only in DONE; q and sticky SHALL hold stable throughout DONE.
REQ-025 On DONE with out_ready high, the block SHALL return to IDLE at that edge; in_ready SHALL be low in DONE (no overlap), giving a minimum issue period of QW+2 cycles.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 in_valid SHALL be ignored outside IDLE.
REQ-028 kill SHALL force IDLE at the next edge from any state and discard the operation.
REQ-029 When kill and in_valid are high in the same cycle, the input SHALL NOT be accepted.
REQ-030 When kill coincides with an out handshake, the result is taken as consumed.
REQ-031 For non-normalised operands, q and sticky are unspecified, but the FSM SHALL still reach DONE after QW cycles.
REQ-032 Remainder registers SHALL be sized so that no intermediate overflow occurs for any normalised input: div remainder MW+1 bits, sqrt remainder QW+2 bits.

Reset
REQ-033 While reset is high, the block SHALL enter IDLE and clear state, counter, remainder, q, sticky and out_valid; in_ready SHALL be 0.
REQ-034 reset SHALL take priority over kill and over all handshakes.
REQ-035 Reset mid-BUSY or mid-DONE SHALL discard the operation with no out_valid pulse.

Structure
REQ-036 The FSM state encoding (IDLE/BUSY/DONE) and the op encoding constants SHALL live in package fp_wire.
REQ-037 The width-dependent register record SHALL be declared locally in the module, because it depends on MW.
REQ-038 The single-bit recurrence SHALL be a combinational sub-module fp_divsqrt_step (inputs: remainder, partial root or divisor, op; outputs: next remainder, result bit).
REQ-039 fp_divsqrt_step SHALL be parametrised by MW.

Verification (MW=24, QW=26)
REQ-040 Div a=0x800000, b=0x800000 -> q=0x2000000, sticky=0, out_valid exactly 26 cycles after accept.
REQ-041 Div a=0x800000, b=0xC00000 -> q=0x1555555, sticky=1.
REQ-042 Sqrt a=0x800000 odd=0 -> q=0x2000000, sticky=0; odd=1 -> q=0x2D413CC, sticky=1; a=0x900000 odd=1 -> q=0x3000000, sticky=0.
REQ-043 out_ready held low 10 cycles in DONE -> out_valid, q and sticky stable, in_ready=0; out_ready=1 -> IDLE and in_ready=1 the next cycle; back-to-back ops at a period of 28 cycles.
REQ-044 kill on BUSY cycle 5 -> no out_valid, in_ready=1 the next cycle, and a following op gives the correct result; kill with in_valid in IDLE -> not accepted.
REQ-045 reset asserted in BUSY and in DONE -> all outputs 0 the next cycle, then normal operation resumes.
REQ-046 MW=53 run: div 1.0/1.0 -> q=2^54, latency 55 cycles.
